// File: rtl/ps2_key_sender.sv
// ps2_key_sender: PS/2 device-side transmitter. Accepts key events on a
// valid/ready handshake and serialises them as 1..3 scancode frames
// (optional E0, optional F0, code) on ps2clk/ps2data.
// Optional feature macro: PS2_KEY_SENDER_BREAK_EN. When it is defined,
// key_break inserts the F0 prefix; when it is not, break events are
// accepted and silently discarded.
module ps2_key_sender #(
  parameter int clk_mhz    = 25,
  parameter int quarter_us = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  input  logic       key_ext,
  input  logic       key_break,
  output logic       ps2clk,
  output logic       ps2data,
  output logic       busy
);

  // Cycles per quarter bit period.
  localparam int Q  = clk_mhz * quarter_us;
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;

`ifdef PS2_KEY_SENDER_BREAK_EN
  localparam bit break_en = 1'b1;
`else
  localparam bit break_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_GAP
  } state_t;

  state_t          state, state_n;
  logic [QW-1:0]   qcnt, qcnt_n;
  logic [1:0]      quarter, quarter_n;
  logic [3:0]      bit_idx, bit_idx_n;
  logic [7:0]      cur_byte, cur_byte_n;
  logic [7:0]      code_q, code_q_n;
  logic            pend_f0, pend_f0_n;
  logic            pend_code, pend_code_n;
  logic            key_ready_n, busy_n, ps2clk_n, ps2data_n;
  logic            accept, drop_break, q_last;

  assign accept     = (state == S_IDLE) && key_ready && key_valid;
  assign drop_break = key_break && !break_en;
  assign q_last     = (qcnt == QW'(Q - 1));

  // Line level for bit position idx of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [2:0] sel;
    sel = 3'(idx - 4'd1);
    case (idx)
      4'd0:    return 1'b0;
      4'd9:    return ~^b;
      4'd10:   return 1'b1;
      default: return (idx <= 4'd8) ? b[sel] : 1'b1;
    endcase
  endfunction

  // Next-state and next-output logic; outputs are computed from the next
  // state so that the registered lines change on the same edge as the FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_n     = state;
    qcnt_n      = qcnt;
    quarter_n   = quarter;
    bit_idx_n   = bit_idx;
    cur_byte_n  = cur_byte;
    code_q_n    = code_q;
    pend_f0_n   = pend_f0;
    pend_code_n = pend_code;
    key_ready_n = key_ready;
    busy_n      = busy;

    case (state)
      S_IDLE: begin
        key_ready_n = 1'b1;
        busy_n      = 1'b0;
        if (accept) begin
          // Ready drops for one cycle on every acceptance, even a discarded one.
          key_ready_n = 1'b0;
          if (!drop_break) begin
            state_n   = S_FRAME;
            qcnt_n    = '0;
            quarter_n = '0;
            bit_idx_n = '0;
            busy_n    = 1'b1;
            code_q_n  = key_code;
            if (key_ext) begin
              cur_byte_n  = 8'hE0;
              pend_f0_n   = key_break;
              pend_code_n = 1'b1;
            end else if (key_break) begin
              cur_byte_n  = 8'hF0;
              pend_f0_n   = 1'b0;
              pend_code_n = 1'b1;
            end else begin
              cur_byte_n  = key_code;
              pend_f0_n   = 1'b0;
              pend_code_n = 1'b0;
            end
          end
        end
      end

      S_FRAME: begin
        qcnt_n = qcnt + QW'(1);
        if (q_last) begin
          qcnt_n    = '0;
          quarter_n = quarter + 2'd1;
          if (quarter == 2'd3) begin
            if (bit_idx == 4'd10) begin
              state_n   = S_GAP;
              bit_idx_n = '0;
            end else begin
              bit_idx_n = bit_idx + 4'd1;
            end
          end
        end
      end

      S_GAP: begin
        qcnt_n = qcnt + QW'(1);
        if (q_last) begin
          qcnt_n    = '0;
          quarter_n = quarter + 2'd1;
          if (quarter == 2'd3) begin
            if (pend_f0) begin
              state_n    = S_FRAME;
              cur_byte_n = 8'hF0;
              pend_f0_n  = 1'b0;
            end else if (pend_code) begin
              state_n     = S_FRAME;
              cur_byte_n  = code_q;
              pend_code_n = 1'b0;
            end else begin
              state_n     = S_IDLE;
              key_ready_n = 1'b1;
              busy_n      = 1'b0;
            end
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Clock high in quarters 0-1, low in 2-3; data follows the bit index.
    ps2clk_n  = (state_n == S_FRAME) ? ~quarter_n[1] : 1'b1;
    ps2data_n = (state_n == S_FRAME) ? frame_bit(cur_byte_n, bit_idx_n) : 1'b1;
  end

  // State and output registers with synchronous reset; reset aborts any frame.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      quarter   <= '0;
      bit_idx   <= '0;
      cur_byte  <= '0;
      code_q    <= '0;
      pend_f0   <= 1'b0;
      pend_code <= 1'b0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      ps2clk    <= 1'b1;
      ps2data   <= 1'b1;
    end else begin
      state     <= state_n;
      qcnt      <= qcnt_n;
      quarter   <= quarter_n;
      bit_idx   <= bit_idx_n;
      cur_byte  <= cur_byte_n;
      code_q    <= code_q_n;
      pend_f0   <= pend_f0_n;
      pend_code <= pend_code_n;
      key_ready <= key_ready_n;
      busy      <= busy_n;
      ps2clk    <= ps2clk_n;
      ps2data   <= ps2data_n;
    end
  end

endmodule

// File: tb/tb_ps2_key_sender.sv
// tb_ps2_key_sender: directed stimulus for ps2_key_sender. Expected frames
// (byte plus hand-computed parity) are queued when an event is issued; a
// PS/2 receiver monitor decodes the lines and compares against the queue.
module tb_ps2_key_sender;

  localparam int CLK_MHZ    = 2;
  localparam int QUARTER_US = 3;
  localparam int Q          = CLK_MHZ * QUARTER_US;
  localparam int BUDGET     = 200 * Q;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_ext = 1'b0;
  logic       key_break = 1'b0;
  logic       key_ready, ps2clk, ps2data, busy;

  ps2_key_sender #(
    .clk_mhz   (CLK_MHZ),
    .quarter_us(QUARTER_US)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_code (key_code),
    .key_ext  (key_ext),
    .key_break(key_break),
    .ps2clk   (ps2clk),
    .ps2data  (ps2data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] b;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fall_count = 0;
  bit   mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver monitor: frame decode, edge spacing and data setup/hold.
  initial begin
    logic        prev_clk, prev_data;
    logic [10:0] bits;
    int          bitcnt, last_fall, last_chg;
    exp_t        e;
    prev_clk = 1'b1; prev_data = 1'b1; bits = '0;
    bitcnt = 0; last_fall = -1; last_chg = -1;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        bitcnt = 0; last_fall = -1; last_chg = -1;
      end else begin
        if (ps2data !== prev_data) begin
          check("data_change_clk_high", 32'(ps2clk), 32'd1);
          if (last_fall >= 0) check("data_hold", 32'(cyc - last_fall >= 2 * Q), 32'd1);
          last_chg = cyc;
        end
        if (prev_clk === 1'b1 && ps2clk === 1'b0) begin
          fall_count++;
          if (last_chg >= 0) check("data_setup", 32'(cyc - last_chg >= 2 * Q), 32'd1);
          if (bitcnt > 0) check("fall_spacing", 32'(cyc - last_fall), 32'(4 * Q));
          else if (last_fall >= 0) check("gap_spacing", 32'(cyc - last_fall >= 8 * Q), 32'd1);
          bits = {ps2data, bits[10:1]};
          bitcnt++;
          last_fall = cyc;
          if (bitcnt == 11) begin
            bitcnt = 0;
            check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("frame_start", 32'(bits[0]), 32'd0);
              check("frame_byte", 32'(bits[8:1]), 32'(e.b));
              check("frame_parity", 32'(bits[9]), 32'(e.p));
              check("frame_stop", 32'(bits[10]), 32'd1);
            end
          end
        end
      end
      prev_clk = ps2clk;
      prev_data = ps2data;
    end
  end

  // Present an event, wait (bounded) for acceptance, check the next sample.
  task automatic issue(input logic [7:0] code, input logic ext, input logic brk,
                       input logic par, input bit hold, output int acc);
    int n;
    bit drop;
`ifdef PS2_KEY_SENDER_BREAK_EN
    drop = 1'b0;
`else
    drop = brk;
`endif
    if (!drop) begin
      if (ext) exp_q.push_back({8'hE0, 1'b0});
      if (brk) exp_q.push_back({8'hF0, 1'b1});
      exp_q.push_back({code, par});
    end
    key_code = code; key_ext = ext; key_break = brk; key_valid = 1'b1;
    n = 0;
    while (key_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("ready_within_budget", 32'(key_ready === 1'b1), 32'd1);
    @(negedge clk);
    acc = cyc;
    if (!hold) key_valid = 1'b0;
    check("accept_ready_low", 32'(key_ready), 32'd0);
    check("accept_busy", 32'(busy), 32'(!drop));
    check("accept_data", 32'(ps2data), 32'(drop));
    check("accept_clk", 32'(ps2clk), 32'd1);
  endtask

  // Follow an accepted event to its end: busy length, first fall, edge count.
  task automatic measure(input int frames, input int acc, input int falls0);
    int n, len, first;
    n = 0; len = 1; first = -1;
    while (busy === 1'b1 && n < 60 * Q * frames) begin
      @(negedge clk);
      n++;
      if (ps2clk === 1'b0 && first < 0) first = cyc - acc;
      if (busy === 1'b1) len++;
    end
    check("busy_length", 32'(len), 32'(48 * Q * frames));
    check("first_fall_offset", 32'(first), 32'(2 * Q));
    check("ready_after_event", 32'(key_ready), 32'd1);
    check("falls_per_event", 32'(fall_count - falls0), 32'(11 * frames));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy === 1'b0 && key_ready === 1'b1) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(busy === 1'b0 && key_ready === 1'b1), 32'd1);
  endtask

  initial begin
    int acc, acc2, f0, n, lows;
    repeat (3) @(negedge clk);
    check("reset_clk", 32'(ps2clk), 32'd1);
    check("reset_data", 32'(ps2data), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(key_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_release", 32'(key_ready), 32'd1);

    // Make 'A' (0x1C): one frame, parity 0.
    f0 = fall_count;
    issue(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    measure(1, acc, f0);

    // Extended make 0x6B: E0 then 6B (parity 0).
    f0 = fall_count;
    issue(8'h6B, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    measure(2, acc, f0);

`ifdef PS2_KEY_SENDER_BREAK_EN
    // Extended break 0x74: E0, F0, 74 (parity 1).
    f0 = fall_count;
    issue(8'h74, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    measure(3, acc, f0);
`else
    // Break events are swallowed: one-cycle ready drop, lines stay idle.
    issue(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    @(negedge clk);
    check("discard_ready_back", 32'(key_ready), 32'd1);
    issue(8'h74, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    @(negedge clk);
    check("discard_ext_ready_back", 32'(key_ready), 32'd1);
    lows = 0;
    repeat (10 * Q) begin
      @(negedge clk);
      if (busy !== 1'b0 || ps2clk !== 1'b1 || ps2data !== 1'b1) lows++;
    end
    check("discard_lines_idle", 32'(lows), 32'd0);
`endif

    // key_valid pulsed while busy must be ignored (0x5A, parity 1).
    f0 = fall_count;
    issue(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    repeat (8 * Q) @(negedge clk);
    key_code = 8'h1C; key_valid = 1'b1;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    wait_idle();
    repeat (60 * Q) @(negedge clk);
    check("busy_valid_not_queued", 32'(fall_count - f0), 32'd11);

    // key_valid held: 0x32 (parity 0) then 0x21 (parity 1); inputs change mid-frame.
    f0 = fall_count;
    issue(8'h32, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    issue(8'h21, 1'b0, 1'b0, 1'b1, 1'b0, acc2);
    check("held_accept_spacing", 32'(acc2 - acc), 32'(48 * Q + 1));
    wait_idle();
    check("held_falls", 32'(fall_count - f0), 32'd22);

    // Reset during bit 5, quarter 2.
    f0 = fall_count;
    issue(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    n = 0;
    while (fall_count - f0 < 6 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit5", 32'(fall_count - f0), 32'd6);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort_clk", 32'(ps2clk), 32'd1);
    check("abort_data", 32'(ps2data), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_ready_after_release", 32'(key_ready), 32'd1);
    lows = 0;
    repeat (12 * Q) begin
      @(negedge clk);
      if (ps2clk !== 1'b1 || ps2data !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("abort_no_resend", 32'(lows), 32'd0);
    mon_en = 1'b1;

    repeat (20 * Q) @(negedge clk);
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound on run length.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
